// File: rtl/lbp_histogram.sv
// 256-bin histogram of an LBP code stream: clear, accumulate until finish, dump bins over valid/ready.
// Optional LBP_HIST_SKIP_ZERO_EN: the dump emits only nonzero bins (empty frame -> single beat 255/0/last).
module lbp_histogram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              acc_ready,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [DATA_W-1:0] hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_last
);

  localparam int unsigned BINS  = 2 ** DATA_W;
  localparam int unsigned IDX_W = DATA_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] LAST_BIN = '1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_ACCUM = 2'd1,
    S_DUMP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [CNT_W-1:0]    bin_q [BINS];
  logic [CNT_W-1:0]    bin_d [BINS];

  logic                acc_ready_q, acc_ready_d;
  logic                hist_valid_q, hist_valid_d;
  logic [DATA_W-1:0]   hist_bin_q, hist_bin_d;
  logic [CNT_W-1:0]    hist_count_q, hist_count_d;
  logic                hist_last_q, hist_last_d;

  logic                xfer;
  logic [DATA_W-1:0]   sel_idx;
  logic                sel_last;
  logic [CNT_W-1:0]    sel_count;

  assign xfer = hist_valid_q & hist_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_ptr_q == LAST_BIN) state_d = S_ACCUM;
      S_ACCUM: if (finish) state_d = S_DUMP;
      S_DUMP:  if (xfer && hist_last_q) state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase
  end

  // Bin storage update: sweep-clear in CLEAR, saturating increment in ACCUM
  always_comb begin
    bin_d     = bin_q;
    clr_ptr_d = '0;
    case (state_q)
      S_CLEAR: begin
        bin_d[clr_ptr_q] = '0;
        clr_ptr_d        = clr_ptr_q + DATA_W'(1);
      end
      S_ACCUM: begin
        if (lbp_valid && (bin_q[lbp_data] != CNT_MAX)) begin
          bin_d[lbp_data] = bin_q[lbp_data] + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef LBP_HIST_SKIP_ZERO_EN
  logic [BINS-1:0]  nz;
  logic [IDX_W-1:0] search_start;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] above_idx;

  // Lowest set index of m at or above start; BINS when none
  function automatic logic [IDX_W-1:0] lowest_from(input logic [BINS-1:0]  m,
                                                   input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] res;
    res = IDX_W'(BINS);
    for (int i = int'(BINS) - 1; i >= 0; i--) begin
      if (m[i] && (IDX_W'(i) >= start)) res = IDX_W'(i);
    end
    return res;
  endfunction

  // Next nonzero bin and whether any nonzero bin lies beyond it, both in one cycle
  always_comb begin
    for (int i = 0; i < int'(BINS); i++) begin
      nz[i] = (bin_d[i] != '0);
    end
    search_start = (state_q == S_ACCUM) ? '0 : (IDX_W'(hist_bin_q) + IDX_W'(1));
    first_idx    = lowest_from(nz, search_start);
    above_idx    = lowest_from(nz, first_idx + IDX_W'(1));
    if (first_idx == IDX_W'(BINS)) begin
      sel_idx  = LAST_BIN;
      sel_last = 1'b1;
    end else begin
      sel_idx  = first_idx[DATA_W-1:0];
      sel_last = (above_idx == IDX_W'(BINS));
    end
  end
`else
  // Every bin is emitted in order
  always_comb begin
    sel_idx  = (state_q == S_ACCUM) ? '0 : (hist_bin_q + DATA_W'(1));
    sel_last = (sel_idx == LAST_BIN);
  end
`endif

  // bin_d so the sample accepted alongside finish is reflected in the first beat
  assign sel_count = bin_d[sel_idx];

  // Output logic
  always_comb begin
    acc_ready_d  = (state_d == S_ACCUM);
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_last_d  = hist_last_q;
    case (state_q)
      S_ACCUM: begin
        if (finish) begin
          hist_valid_d = 1'b1;
          hist_bin_d   = sel_idx;
          hist_count_d = sel_count;
          hist_last_d  = sel_last;
        end
      end
      S_DUMP: begin
        if (xfer) begin
          if (hist_last_q) begin
            hist_valid_d = 1'b0;
            hist_bin_d   = '0;
            hist_count_d = '0;
            hist_last_d  = 1'b0;
          end else begin
            hist_bin_d   = sel_idx;
            hist_count_d = sel_count;
            hist_last_d  = sel_last;
          end
        end
      end
      default: begin
        hist_valid_d = 1'b0;
        hist_bin_d   = '0;
        hist_count_d = '0;
        hist_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_ptr_q    <= '0;
      acc_ready_q  <= 1'b0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
      hist_count_q <= '0;
      hist_last_q  <= 1'b0;
    end else begin
      clr_ptr_q    <= clr_ptr_d;
      acc_ready_q  <= acc_ready_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_last_q  <= hist_last_d;
    end
  end

  // Bin array is initialised by the CLEAR sweep, so it carries no reset
  always_ff @(posedge clk) begin
    bin_q <= bin_d;
  end

  assign acc_ready  = acc_ready_q;
  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = hist_count_q;
  assign hist_last  = hist_last_q;

endmodule

// File: tb/tb_lbp_histogram.sv
// Directed bench for lbp_histogram: a default instance plus a CNT_W=4 instance sharing stimulus.
module tb_lbp_histogram;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned SAT_W  = 4;
  localparam int unsigned BINS   = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              lbp_valid;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              hist_ready;

  logic              acc_ready, hist_valid, hist_last;
  logic [DATA_W-1:0] hist_bin;
  logic [CNT_W-1:0]  hist_count;

  logic              acc_ready_s, hist_valid_s, hist_last_s;
  logic [DATA_W-1:0] hist_bin_s;
  logic [SAT_W-1:0]  hist_count_s;

  lbp_histogram #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
    .acc_ready(acc_ready), .hist_valid(hist_valid), .hist_ready(hist_ready),
    .hist_bin(hist_bin), .hist_count(hist_count), .hist_last(hist_last)
  );

  lbp_histogram #(.DATA_W(DATA_W), .CNT_W(SAT_W)) sat_dut (
    .clk(clk), .reset(rst_n), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
    .acc_ready(acc_ready_s), .hist_valid(hist_valid_s), .hist_ready(hist_ready),
    .hist_bin(hist_bin_s), .hist_count(hist_count_s), .hist_last(hist_last_s)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] beat_bin  [BINS];
  logic [CNT_W-1:0]  beat_cnt  [BINS];
  logic              beat_last [BINS];
  int                n_beats;
  int                exp_hist  [BINS];
  int                sat_hist  [BINS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic f);
    lbp_valid = v;
    lbp_data  = d;
    finish    = f;
    @(negedge clk);
    lbp_valid = 1'b0;
    lbp_data  = '0;
    finish    = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < int'(BINS); i++) begin
      exp_hist[i] = 0;
      sat_hist[i] = 0;
    end
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!acc_ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_acc_ready", 32'(acc_ready), 32'd1);
  endtask

  // pattern 0: hist_ready always 1; pattern 1: ready repeats 1,0,0
  task automatic collect(input string tag, input int pattern);
    int cyc = 0;
    int ph  = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] pb;
    logic [CNT_W-1:0]  pc;
    logic              pl;
    pb = '0; pc = '0; pl = 1'b0;
    n_beats = 0;
    hist_ready = 1'b1;
    while (!done && cyc < 2000) begin
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, 32'(hist_valid), 32'd1);
        chk({tag, "_stall_bin"},   32'(hist_bin),   32'(pb));
        chk({tag, "_stall_cnt"},   32'(hist_count), 32'(pc));
        chk({tag, "_stall_last"},  32'(hist_last),  32'(pl));
      end
      if (hist_valid && hist_ready) begin
        if (n_beats < int'(BINS)) begin
          beat_bin[n_beats]  = hist_bin;
          beat_cnt[n_beats]  = hist_count;
          beat_last[n_beats] = hist_last;
        end
        n_beats++;
        if (hist_last) done = 1'b1;
      end
      if (hist_valid_s && hist_ready) sat_hist[hist_bin_s] = int'(hist_count_s);
      prev_stall = hist_valid && !hist_ready;
      pb = hist_bin; pc = hist_count; pl = hist_last;
      if (!done) begin
        @(negedge clk);
        cyc++;
        ph++;
        hist_ready = (pattern == 0) ? 1'b1 : ((ph % 3) == 0);
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(hist_valid), 32'd0);
    hist_ready = 1'b0;
  endtask

  task automatic verify(input string tag);
    logic [DATA_W-1:0] eb [$];
    int                ec [$];
`ifdef LBP_HIST_SKIP_ZERO_EN
    for (int i = 0; i < int'(BINS); i++) begin
      if (exp_hist[i] != 0) begin
        eb.push_back(DATA_W'(i));
        ec.push_back(exp_hist[i]);
      end
    end
    if (eb.size() == 0) begin
      eb.push_back(8'hFF);
      ec.push_back(0);
    end
`else
    for (int i = 0; i < int'(BINS); i++) begin
      eb.push_back(DATA_W'(i));
      ec.push_back(exp_hist[i]);
    end
`endif
    chk({tag, "_beats"}, 32'(n_beats), 32'(eb.size()));
    for (int i = 0; i < n_beats && i < eb.size(); i++) begin
      chk($sformatf("%s_bin%0d", tag, i),  32'(beat_bin[i]),  32'(eb[i]));
      chk($sformatf("%s_cnt%0d", tag, i),  32'(beat_cnt[i]),  32'(ec[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(beat_last[i]), 32'(i == eb.size() - 1));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    lbp_valid  = 1'b0;
    lbp_data   = '0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    clear_exp();

    // 1: reset values and exact CLEAR length
    repeat (3) @(negedge clk);
    chk("rst_acc_ready",  32'(acc_ready),  32'd0);
    chk("rst_hist_valid", 32'(hist_valid), 32'd0);
    chk("rst_hist_bin",   32'(hist_bin),   32'd0);
    chk("rst_hist_count", 32'(hist_count), 32'd0);
    chk("rst_hist_last",  32'(hist_last),  32'd0);
    rst_n = 1'b1;
    repeat (255) @(negedge clk);
    chk("clear_255_acc_ready", 32'(acc_ready),  32'd0);
    chk("clear_255_valid",     32'(hist_valid), 32'd0);
    @(negedge clk);
    chk("clear_256_acc_ready", 32'(acc_ready), 32'd1);

    // 2: full frame of one code
    clear_exp();
    for (int i = 0; i < 16384; i++) step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_first_valid", 32'(hist_valid), 32'd1);
    chk("t2_acc_ready_low", 32'(acc_ready), 32'd0);
    exp_hist[8'h5A] = 16384;
    collect("t2", 0);
    verify("t2");

    // 3: sample in the finish cycle is counted
    wait_ready();
    clear_exp();
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    chk("t3_first_valid", 32'(hist_valid), 32'd1);
    chk("t3_first_bin",   32'(hist_bin),   32'd0);
    chk("t3_first_count", 32'(hist_count), 32'd2);
    exp_hist[0]   = 2;
    exp_hist[255] = 1;
    collect("t3", 0);
    verify("t3");

    // 4: backpressure pattern 1,0,0
    wait_ready();
    clear_exp();
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    step(1'b0, 8'd9, 1'b0);
    step(1'b1, 8'd200, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    exp_hist[1] = 1; exp_hist[2] = 1; exp_hist[3] = 2; exp_hist[200] = 1;
    collect("t4", 1);
    verify("t4");

    // 5: saturation on the narrow-counter instance
    wait_ready();
    clear_exp();
    for (int i = 0; i < 20; i++) step(1'b1, 8'd3, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    exp_hist[3] = 20;
    collect("t5", 0);
    verify("t5");
    chk("t5_sat_bin3", 32'(sat_hist[3]), 32'd15);

    // 6: reset in the middle of a dump, then an empty frame
    wait_ready();
    clear_exp();
    for (int i = 0; i < 5; i++) step(1'b1, 8'd100, 1'b0);
    step(1'b1, 8'd7, 1'b1);
    hist_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (hist_valid && hist_bin == 8'd100) break;
      @(negedge clk);
    end
    chk("t6_reached_bin100", 32'(hist_bin), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(hist_valid), 32'd0);
    chk("t6_rst_last",  32'(hist_last),  32'd0);
    chk("t6_rst_bin",   32'(hist_bin),   32'd0);
    chk("t6_rst_count", 32'(hist_count), 32'd0);
    hist_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (255) @(negedge clk);
    chk("t6_clear_255", 32'(acc_ready), 32'd0);
    @(negedge clk);
    chk("t6_clear_256", 32'(acc_ready), 32'd1);
    step(1'b0, 8'd0, 1'b1);
    chk("t6_empty_valid", 32'(hist_valid), 32'd1);
    collect("t6", 0);
    verify("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
